// File: rtl/multisim_axi_outstanding_limiter.sv
// AXI pass-through that caps outstanding writes/reads toward the multisim
// push client, orders W behind AW, and flags timeouts and stray responses.
module multisim_axi_outstanding_limiter #(
  parameter type axi_aw_t = logic,
  parameter type axi_w_t  = logic,
  parameter type axi_b_t  = logic,
  parameter type axi_ar_t = logic,
  parameter type axi_r_t  = logic,
  parameter int unsigned MAX_WR = 4,
  parameter int unsigned MAX_RD = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CW =
    $clog2(((MAX_WR > MAX_RD) ? MAX_WR : MAX_RD) + 1)
) (
  input  logic    clk,
  input  logic    rst_n,
  input  axi_aw_t i_axi_s_aw,
  input  logic    i_axi_s_awvalid,
  output logic    o_axi_s_awready,
  input  axi_w_t  i_axi_s_w,
  input  logic    i_axi_s_wvalid,
  output logic    o_axi_s_wready,
  output axi_b_t  o_axi_s_b,
  output logic    o_axi_s_bvalid,
  input  logic    i_axi_s_bready,
  input  axi_ar_t i_axi_s_ar,
  input  logic    i_axi_s_arvalid,
  output logic    o_axi_s_arready,
  output axi_r_t  o_axi_s_r,
  output logic    o_axi_s_rvalid,
  input  logic    i_axi_s_rready,
  output axi_aw_t o_axi_m_aw,
  output logic    o_axi_m_awvalid,
  input  logic    i_axi_m_awready,
  output axi_w_t  o_axi_m_w,
  output logic    o_axi_m_wvalid,
  input  logic    i_axi_m_wready,
  input  axi_b_t  i_axi_m_b,
  input  logic    i_axi_m_bvalid,
  output logic    o_axi_m_bready,
  output axi_ar_t o_axi_m_ar,
  output logic    o_axi_m_arvalid,
  input  logic    i_axi_m_arready,
  input  axi_r_t  i_axi_m_r,
  input  logic    i_axi_m_rvalid,
  output logic    o_axi_m_rready,
  output logic [CW-1:0] o_wr_outstanding,
  output logic [CW-1:0] o_rd_outstanding,
  output logic    o_timeout,
  output logic    o_protocol_err
);

  localparam int TW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] WR_MAX = CW'(MAX_WR);
  localparam logic [CW-1:0] RD_MAX = CW'(MAX_RD);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] wr_cnt, wr_nxt;
  logic [CW-1:0] rd_cnt, rd_nxt;
  logic [CW-1:0] w_pend, w_pend_nxt;
  logic [TW-1:0] tmo, tmo_nxt;
  logic          tmo_err_nxt, perr_nxt;
  logic          wr_ok, rd_ok, w_ok;
  logic          aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign wr_ok = (wr_cnt < WR_MAX);
  assign rd_ok = (rd_cnt < RD_MAX);
  assign w_ok  = (w_pend != '0);

  assign o_axi_m_aw      = i_axi_s_aw;
  assign o_axi_m_awvalid = i_axi_s_awvalid & wr_ok;
  assign o_axi_s_awready = i_axi_m_awready & wr_ok;

  assign o_axi_m_w       = i_axi_s_w;
  assign o_axi_m_wvalid  = i_axi_s_wvalid & w_ok;
  assign o_axi_s_wready  = i_axi_m_wready & w_ok;

  assign o_axi_s_b       = i_axi_m_b;
  assign o_axi_s_bvalid  = i_axi_m_bvalid;
  assign o_axi_m_bready  = i_axi_s_bready;

  assign o_axi_m_ar      = i_axi_s_ar;
  assign o_axi_m_arvalid = i_axi_s_arvalid & rd_ok;
  assign o_axi_s_arready = i_axi_m_arready & rd_ok;

  assign o_axi_s_r       = i_axi_m_r;
  assign o_axi_s_rvalid  = i_axi_m_rvalid;
  assign o_axi_m_rready  = i_axi_s_rready;

  assign aw_hs = i_axi_s_awvalid & o_axi_s_awready;
  assign w_hs  = i_axi_s_wvalid & o_axi_s_wready;
  assign b_hs  = i_axi_m_bvalid & i_axi_s_bready;
  assign ar_hs = i_axi_s_arvalid & o_axi_s_arready;
  assign r_hs  = i_axi_m_rvalid & i_axi_s_rready;

  assign o_wr_outstanding = wr_cnt;
  assign o_rd_outstanding = rd_cnt;

  always_comb begin
    wr_nxt = wr_cnt;
    case ({aw_hs, b_hs})
      2'b10:   wr_nxt = wr_cnt + ONE;
      2'b01:   if (wr_cnt != '0) wr_nxt = wr_cnt - ONE;
      default: wr_nxt = wr_cnt;
    endcase

    rd_nxt = rd_cnt;
    case ({ar_hs, r_hs})
      2'b10:   rd_nxt = rd_cnt + ONE;
      2'b01:   if (rd_cnt != '0) rd_nxt = rd_cnt - ONE;
      default: rd_nxt = rd_cnt;
    endcase

    w_pend_nxt = w_pend;
    case ({aw_hs, w_hs})
      2'b10:   if (w_pend != WR_MAX) w_pend_nxt = w_pend + ONE;
      2'b01:   w_pend_nxt = w_pend - ONE;
      default: w_pend_nxt = w_pend;
    endcase

    perr_nxt = o_protocol_err
             | (b_hs & (wr_cnt == '0))
             | (r_hs & (rd_cnt == '0));

    // Idle (nothing outstanding) or any response restarts the window.
    tmo_nxt = tmo;
    if (b_hs | r_hs | ((wr_cnt == '0) & (rd_cnt == '0)))
      tmo_nxt = '0;
    else if (tmo != TMO_MAX)
      tmo_nxt = tmo + TW'(1);

    tmo_err_nxt = o_timeout
                | ((TIMEOUT_CYCLES != 0) & (tmo_nxt == TMO_MAX));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt         <= '0;
      rd_cnt         <= '0;
      w_pend         <= '0;
      tmo            <= '0;
      o_timeout      <= 1'b0;
      o_protocol_err <= 1'b0;
    end else begin
      wr_cnt         <= wr_nxt;
      rd_cnt         <= rd_nxt;
      w_pend         <= w_pend_nxt;
      tmo            <= tmo_nxt;
      o_timeout      <= tmo_err_nxt;
      o_protocol_err <= perr_nxt;
    end
  end

endmodule

// File: tb/tb_multisim_axi_outstanding_limiter.sv
// Directed bench: caps, W ordering, simultaneous events, timeout,
// protocol error and asynchronous reset of the outstanding limiter.
module tb_multisim_axi_outstanding_limiter;

  typedef logic [7:0] pl_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pl_t  s_aw, s_w, s_ar, m_b, m_r;
  logic s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready;
  logic m_awready, m_wready, m_arready, m_bvalid, m_rvalid;

  pl_t  o_s_b, o_s_r, o_m_aw, o_m_w, o_m_ar;
  logic s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic [2:0] wr_out, rd_out;
  logic tmo, perr;

  pl_t  d2_s_b, d2_s_r, d2_m_aw, d2_m_w, d2_m_ar;
  logic d2_awready, d2_wready, d2_bvalid, d2_arready, d2_rvalid;
  logic d2_awvalid, d2_wvalid, d2_bready, d2_arvalid, d2_rready;
  logic [2:0] d2_wr_out, d2_rd_out;
  logic d2_tmo, d2_perr;

  multisim_axi_outstanding_limiter #(
    .axi_aw_t(pl_t), .axi_w_t(pl_t), .axi_b_t(pl_t),
    .axi_ar_t(pl_t), .axi_r_t(pl_t),
    .MAX_WR(2), .MAX_RD(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_axi_s_aw(s_aw), .i_axi_s_awvalid(s_awvalid),
    .o_axi_s_awready(s_awready),
    .i_axi_s_w(s_w), .i_axi_s_wvalid(s_wvalid),
    .o_axi_s_wready(s_wready),
    .o_axi_s_b(o_s_b), .o_axi_s_bvalid(s_bvalid),
    .i_axi_s_bready(s_bready),
    .i_axi_s_ar(s_ar), .i_axi_s_arvalid(s_arvalid),
    .o_axi_s_arready(s_arready),
    .o_axi_s_r(o_s_r), .o_axi_s_rvalid(s_rvalid),
    .i_axi_s_rready(s_rready),
    .o_axi_m_aw(o_m_aw), .o_axi_m_awvalid(m_awvalid),
    .i_axi_m_awready(m_awready),
    .o_axi_m_w(o_m_w), .o_axi_m_wvalid(m_wvalid),
    .i_axi_m_wready(m_wready),
    .i_axi_m_b(m_b), .i_axi_m_bvalid(m_bvalid),
    .o_axi_m_bready(m_bready),
    .o_axi_m_ar(o_m_ar), .o_axi_m_arvalid(m_arvalid),
    .i_axi_m_arready(m_arready),
    .i_axi_m_r(m_r), .i_axi_m_rvalid(m_rvalid),
    .o_axi_m_rready(m_rready),
    .o_wr_outstanding(wr_out), .o_rd_outstanding(rd_out),
    .o_timeout(tmo), .o_protocol_err(perr)
  );

  multisim_axi_outstanding_limiter #(
    .axi_aw_t(pl_t), .axi_w_t(pl_t), .axi_b_t(pl_t),
    .axi_ar_t(pl_t), .axi_r_t(pl_t),
    .MAX_WR(2), .MAX_RD(4), .TIMEOUT_CYCLES(0)
  ) dut_notmo (
    .clk(clk), .rst_n(rst_n),
    .i_axi_s_aw(s_aw), .i_axi_s_awvalid(s_awvalid),
    .o_axi_s_awready(d2_awready),
    .i_axi_s_w(s_w), .i_axi_s_wvalid(s_wvalid),
    .o_axi_s_wready(d2_wready),
    .o_axi_s_b(d2_s_b), .o_axi_s_bvalid(d2_bvalid),
    .i_axi_s_bready(s_bready),
    .i_axi_s_ar(s_ar), .i_axi_s_arvalid(s_arvalid),
    .o_axi_s_arready(d2_arready),
    .o_axi_s_r(d2_s_r), .o_axi_s_rvalid(d2_rvalid),
    .i_axi_s_rready(s_rready),
    .o_axi_m_aw(d2_m_aw), .o_axi_m_awvalid(d2_awvalid),
    .i_axi_m_awready(m_awready),
    .o_axi_m_w(d2_m_w), .o_axi_m_wvalid(d2_wvalid),
    .i_axi_m_wready(m_wready),
    .i_axi_m_b(m_b), .i_axi_m_bvalid(m_bvalid),
    .o_axi_m_bready(d2_bready),
    .o_axi_m_ar(d2_m_ar), .o_axi_m_arvalid(d2_arvalid),
    .i_axi_m_arready(m_arready),
    .i_axi_m_r(m_r), .i_axi_m_rvalid(m_rvalid),
    .o_axi_m_rready(d2_rready),
    .o_wr_outstanding(d2_wr_out), .o_rd_outstanding(d2_rd_out),
    .o_timeout(d2_tmo), .o_protocol_err(d2_perr)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    s_aw = '0; s_w = '0; s_ar = '0; m_b = '0; m_r = '0;
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
    s_bready = 0; s_rready = 0;
    m_awready = 0; m_wready = 0; m_arready = 0;
    m_bvalid = 0; m_rvalid = 0;
    #1;
    s_wvalid = 1; m_wready = 1;
    s_awvalid = 1; m_awready = 1;
    #1;
    chk("rst_wr_cnt", 32'(wr_out), 0);
    chk("rst_rd_cnt", 32'(rd_out), 0);
    chk("rst_timeout", 32'(tmo), 0);
    chk("rst_perr", 32'(perr), 0);
    chk("rst_w_blocked", 32'(s_wready), 0);
    chk("rst_mw_blocked", 32'(m_wvalid), 0);
    chk("rst_awready", 32'(s_awready), 1);
    s_wvalid = 0; s_awvalid = 0;
    #10 rst_n = 1'b1;

    // timeout: one read left hanging
    step;
    s_arvalid = 1; s_ar = 8'h33; m_arready = 1;
    #1;
    chk("ar_ready", 32'(s_arready), 1);
    chk("ar_mvalid", 32'(m_arvalid), 1);
    chk("ar_payload", 32'(o_m_ar), 32'h33);
    step;
    s_arvalid = 0;
    chk("rd_cnt_1", 32'(rd_out), 1);
    for (int i = 0; i < 7; i++) step;
    chk("tmo_before", 32'(tmo), 0);
    step;
    chk("tmo_after8", 32'(tmo), 1);
    m_rvalid = 1; m_r = 8'h44; s_rready = 1;
    #1;
    chk("r_payload", 32'(o_s_r), 32'h44);
    chk("r_valid", 32'(s_rvalid), 1);
    chk("r_ready", 32'(m_rready), 1);
    step;
    m_rvalid = 0;
    chk("rd_cnt_drain", 32'(rd_out), 0);
    chk("tmo_sticky", 32'(tmo), 1);
    chk("perr_clean", 32'(perr), 0);
    chk("tmo0_never", 32'(d2_tmo), 0);

    // read side: AR and R in the same cycle at rd_cnt=1
    s_arvalid = 1;
    step;
    chk("rd_cnt_pre", 32'(rd_out), 1);
    m_rvalid = 1;
    step;
    s_arvalid = 0;
    chk("rd_cnt_simul", 32'(rd_out), 1);
    step;
    m_rvalid = 0;
    chk("rd_cnt_zero", 32'(rd_out), 0);

    // W presented 5 cycles ahead of its AW
    s_wvalid = 1; s_w = 8'hA5;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("w_held", 32'(s_wready), 0);
      step;
    end
    s_awvalid = 1; s_aw = 8'h11;
    #1;
    chk("aw_ready", 32'(s_awready), 1);
    chk("aw_payload", 32'(o_m_aw), 32'h11);
    chk("w_same_cyc", 32'(s_wready), 0);
    step;
    s_awvalid = 0;
    chk("w_open", 32'(s_wready), 1);
    chk("w_mvalid", 32'(m_wvalid), 1);
    chk("w_payload", 32'(o_m_w), 32'hA5);
    chk("wr_cnt_1", 32'(wr_out), 1);
    step;
    s_wvalid = 0;

    // AW and B in the same cycle at wr_cnt=1
    s_awvalid = 1; s_aw = 8'h22;
    m_bvalid = 1; m_b = 8'h5C; s_bready = 1;
    #1;
    chk("b_payload", 32'(o_s_b), 32'h5C);
    chk("b_ready", 32'(m_bready), 1);
    step;
    s_awvalid = 0; m_bvalid = 0;
    chk("wr_cnt_simul", 32'(wr_out), 1);
    chk("perr_simul", 32'(perr), 0);
    s_wvalid = 1;
    #1;
    chk("w2_open", 32'(s_wready), 1);
    step;
    s_wvalid = 0;
    m_bvalid = 1;
    step;
    m_bvalid = 0;
    chk("wr_cnt_zero", 32'(wr_out), 0);

    // write cap at MAX_WR=2 with B withheld
    s_awvalid = 1; s_wvalid = 1;
    step;
    chk("cap_wr1", 32'(wr_out), 1);
    chk("cap_w1_ok", 32'(s_wready), 1);
    step;
    #1;
    chk("cap_wr2", 32'(wr_out), 2);
    chk("cap_aw_stall", 32'(s_awready), 0);
    chk("cap_maw_low", 32'(m_awvalid), 0);
    chk("cap_w2_ok", 32'(s_wready), 1);
    step;
    chk("cap_w3_held", 32'(s_wready), 0);
    chk("cap_aw_still", 32'(s_awready), 0);
    m_bvalid = 1;
    #1;
    chk("cap_same_b", 32'(s_awready), 0);
    step;
    m_bvalid = 0;
    chk("cap_wr_after_b", 32'(wr_out), 1);
    chk("cap_aw_reopen", 32'(s_awready), 1);
    step;
    s_awvalid = 0;
    chk("cap_wr2_again", 32'(wr_out), 2);
    chk("cap_w3_ok", 32'(s_wready), 1);
    step;
    s_wvalid = 0;

    // stray R with nothing outstanding
    m_rvalid = 1;
    step;
    m_rvalid = 0;
    chk("perr_set", 32'(perr), 1);
    chk("perr_rd_cnt", 32'(rd_out), 0);

    // asynchronous reset with writes in flight
    chk("pre_rst_wr", 32'(wr_out), 2);
    rst_n = 1'b0;
    #1;
    chk("arst_wr", 32'(wr_out), 0);
    chk("arst_tmo", 32'(tmo), 0);
    chk("arst_perr", 32'(perr), 0);
    #1 rst_n = 1'b1;
    step;
    m_bvalid = 1;
    step;
    m_bvalid = 0;
    chk("late_b_perr", 32'(perr), 1);
    chk("late_b_wr", 32'(wr_out), 0);
    chk("tmo0_end", 32'(d2_tmo), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
